// File: rtl/hi_trace_ctrl_pkg.sv
// Shared definitions for the HF trace capture/readout sequencer.
// Mode codes, state encodings and trace RAM geometry.
package hi_trace_ctrl_pkg;

   localparam logic [2:0] FPGA_MAJOR_MODE_HF_GET_TRACE = 3'd6;
   localparam logic [2:0] FPGA_MAJOR_MODE_OFF          = 3'd7;

   localparam int unsigned TRACE_DEPTH   = 3072;
   localparam int unsigned SSP_BYTE_CLKS = 128;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_POST = 3'd2,
      ST_DONE = 3'd3,
      ST_READ = 3'd4
   } trace_state_e;

endpackage

// File: rtl/hi_trace_ctrl_trace_addr_ctr.sv
// Modulo-DEPTH address counter with load and enable, clocked on the falling edge.
// Exposes its next value and a wrap pulse so the caller can snapshot post-edge pointers.
module trace_addr_ctr
   import hi_trace_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH  = TRACE_DEPTH,
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              en,
   output logic [ADDR_W-1:0] cnt,
   output logic [ADDR_W-1:0] nxt_c,
   output logic              wrap_c
);

   logic last_c;

   assign last_c = (cnt == ADDR_W'(DEPTH - 1));
   assign wrap_c = en & ~load & last_c;

   // load takes precedence over counting
   always_comb begin
      nxt_c = cnt;
      if (load) begin
         nxt_c = load_val;
      end else if (en) begin
         nxt_c = last_c ? '0 : cnt + ADDR_W'(1);
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         cnt <= nxt_c;
      end
   end

endmodule

// File: rtl/hi_trace_ctrl.sv
// Capture and readout sequencer for the HF ADC trace RAM: circular pre-trigger
// capture, post-trigger count, freeze, then oldest-first readout at the SSP byte rate.
module hi_trace_ctrl
   import hi_trace_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH  = TRACE_DEPTH,
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned RD_DIV = SSP_BYTE_CLKS
) (
   input  logic              ck_1356megb,
   input  logic              reset,
   input  logic [2:0]        major_mode,
   input  logic              arm,
   input  logic              trigger,
   input  logic [ADDR_W-1:0] post_count,
   output logic              sample_stb,
   output logic              wr_en,
   output logic              wr_bank,
   output logic [ADDR_W-1:0] addr,
   output logic              rd_load,
   output logic              wrapped,
   output logic              done,
   output logic [2:0]        state_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned RD_W  = $clog2(RD_DIV);
   localparam int unsigned SMP_W = 3;

   trace_state_e state_q, state_d;

   logic [SMP_W-1:0]  smp_div_q;
   logic [RD_W-1:0]   rd_div_q;
   logic [ADDR_W-1:0] post_rem_q;
   logic [ADDR_W-1:0] start_addr_q;
   logic [CNT_W-1:0]  rd_total_q;
   logic [CNT_W-1:0]  rd_count_q;

   logic              mode_off_c, mode_get_c;
   logic              smp_next_c, rd_tick_c;
   logic              arm_go_c, rd_start_c, rd_adv_c, post_dec_c, snap_c;
   logic              ctr_load_c, ctr_en_c, ctr_wrap_c, snap_wrapped_c;
   logic [ADDR_W-1:0] ctr_load_val_c, ctr_nxt_c;

   assign mode_off_c = (major_mode == FPGA_MAJOR_MODE_OFF);
   assign mode_get_c = (major_mode == FPGA_MAJOR_MODE_HF_GET_TRACE);
   assign smp_next_c = (smp_div_q == SMP_W'(7));
   assign rd_tick_c  = (rd_div_q == RD_W'(RD_DIV - 1)) && (rd_count_q != '0);

   // Next state and per-edge actions; mode changes outrank arm, arm outranks trigger
   always_comb begin
      state_d    = state_q;
      arm_go_c   = 1'b0;
      rd_start_c = 1'b0;
      rd_adv_c   = 1'b0;
      post_dec_c = 1'b0;
      snap_c     = 1'b0;
      ctr_en_c   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (mode_get_c) begin
               state_d    = ST_READ;
               rd_start_c = 1'b1;
            end else if (arm) begin
               state_d  = ST_PRE;
               arm_go_c = 1'b1;
            end
         end
         ST_PRE: begin
            if (mode_off_c) begin
               state_d = ST_DONE;
               snap_c  = 1'b1;
            end else if (arm) begin
               arm_go_c = 1'b1;
            end else begin
               // a sample coincident with trigger still counts as pre-trigger
               ctr_en_c = wr_en;
               if (trigger) begin
                  if (post_rem_q == '0) begin
                     state_d = ST_DONE;
                     snap_c  = 1'b1;
                  end else begin
                     state_d = ST_POST;
                  end
               end
            end
         end
         ST_POST: begin
            if (mode_off_c) begin
               state_d = ST_DONE;
               snap_c  = 1'b1;
            end else if (arm) begin
               state_d  = ST_PRE;
               arm_go_c = 1'b1;
            end else if (wr_en) begin
               ctr_en_c   = 1'b1;
               post_dec_c = 1'b1;
               if (post_rem_q == ADDR_W'(1)) begin
                  state_d = ST_DONE;
                  snap_c  = 1'b1;
               end
            end
         end
         ST_READ: begin
            if (!mode_get_c) begin
               state_d = ST_DONE;
            end else begin
               rd_adv_c = rd_tick_c;
               ctr_en_c = rd_tick_c;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign ctr_load_c     = arm_go_c | rd_start_c;
   assign ctr_load_val_c = rd_start_c ? start_addr_q : '0;
   assign snap_wrapped_c = wrapped | ctr_wrap_c;

   trace_addr_ctr #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_addr_ctr (
      .clk      (ck_1356megb),
      .rst      (reset),
      .load     (ctr_load_c),
      .load_val (ctr_load_val_c),
      .en       (ctr_en_c),
      .cnt      (addr),
      .nxt_c    (ctr_nxt_c),
      .wrap_c   (ctr_wrap_c)
   );

   assign wr_bank = addr[ADDR_W-1];
   assign state_o = state_q;

   // Capture bookkeeping and sample strobe
   always_ff @(negedge ck_1356megb or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         smp_div_q    <= '0;
         sample_stb   <= 1'b0;
         wr_en        <= 1'b0;
         wrapped      <= 1'b0;
         done         <= 1'b0;
         post_rem_q   <= '0;
         start_addr_q <= '0;
         rd_total_q   <= '0;
      end else begin
         state_q    <= state_d;
         smp_div_q  <= smp_div_q + SMP_W'(1);
         sample_stb <= smp_next_c;
         wr_en      <= smp_next_c && ((state_d == ST_PRE) || (state_d == ST_POST));
         if (arm_go_c) begin
            wrapped    <= 1'b0;
            done       <= 1'b0;
            post_rem_q <= post_count;
         end else begin
            if (ctr_wrap_c && (state_q != ST_READ)) begin
               wrapped <= 1'b1;
            end
            if (state_d == ST_DONE) begin
               done <= 1'b1;
            end
            if (post_dec_c) begin
               post_rem_q <= post_rem_q - ADDR_W'(1);
            end
         end
         // freeze uses the pointer as it stands after this edge
         if (snap_c) begin
            start_addr_q <= snap_wrapped_c ? ctr_nxt_c : '0;
            rd_total_q   <= snap_wrapped_c ? CNT_W'(DEPTH) : CNT_W'(ctr_nxt_c);
         end
      end
   end

   // Readout byte pacing
   always_ff @(negedge ck_1356megb or posedge reset) begin
      if (reset) begin
         rd_div_q   <= '0;
         rd_count_q <= '0;
         rd_load    <= 1'b0;
      end else if (rd_start_c) begin
         rd_div_q   <= '0;
         rd_count_q <= rd_total_q;
         rd_load    <= (rd_total_q != '0);
      end else begin
         if (state_q == ST_READ) begin
            rd_div_q <= (rd_div_q == RD_W'(RD_DIV - 1)) ? '0 : rd_div_q + RD_W'(1);
         end
         if (rd_adv_c) begin
            rd_count_q <= rd_count_q - CNT_W'(1);
         end
         rd_load <= rd_adv_c && (rd_count_q != CNT_W'(1));
      end
   end

endmodule
